// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request ports and memory bus of the two-port data memory arbiter
interface dmem_arbiter_if;
  logic         req0_valid;
  logic         req0_write;
  logic [31:0]  req0_addr;
  logic [63:0]  req0_wdata;
  logic         req0_done;
  logic         req0_err;
  logic [127:0] req0_rdata;

  logic         req1_valid;
  logic         req1_write;
  logic [31:0]  req1_addr;
  logic [63:0]  req1_wdata;
  logic         req1_done;
  logic         req1_err;
  logic [127:0] req1_rdata;

  logic [31:0]  mem_address;
  logic [63:0]  mem_write_data;
  logic         mem_write;
  logic         mem_read;
  logic [127:0] mem_block_data;
  logic         mem_ready;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_done, req0_err, req0_rdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_done, req1_err, req1_rdata,
    output mem_address, mem_write_data, mem_write, mem_read,
    input  mem_block_data, mem_ready
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_done, req0_err, req0_rdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_done, req1_err, req1_rdata,
    input  mem_address, mem_write_data, mem_write, mem_read,
    output mem_block_data, mem_ready
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter and sequencer for the 1 KB data memory
// One access in flight; reads drain the memory's ready pipeline before the next grant.
module dmem_arbiter #(
  parameter int MEM_BYTES = 1024,
  parameter int TIMEOUT   = 15
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DRAIN} state_t;

  state_t       state;
  logic         last;
  logic         port;
  logic [3:0]   cnt;
  logic [1:0]   done_q;
  logic [1:0]   err_q;
  logic [127:0] rdata_q [2];
  logic [31:0]  address_q;
  logic [63:0]  wdata_q;
  logic         write_q;
  logic         read_q;

  logic         any_valid;
  logic         gnt;
  logic         sel_write;
  logic [31:0]  sel_addr;
  logic [63:0]  sel_wdata;
  logic [31:0]  acc_addr;
  logic [32:0]  acc_end;
  logic         range_bad;
  logic         unused_bits;

  // last holds the most recently granted port, so a tie goes to the other one
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    gnt       = (bus.req0_valid & bus.req1_valid) ? ~last : bus.req1_valid;
    sel_write = gnt ? bus.req1_write : bus.req0_write;
    sel_addr  = gnt ? bus.req1_addr  : bus.req0_addr;
    sel_wdata = gnt ? bus.req1_wdata : bus.req0_wdata;
    acc_addr  = sel_write ? {sel_addr[31:3], 3'b000} : {sel_addr[31:4], 4'b0000};
    acc_end   = {1'b0, acc_addr} + (sel_write ? 33'd8 : 33'd16);
    range_bad = acc_end > 33'(MEM_BYTES);
  end

  assign unused_bits = ^sel_addr[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= 1'b1;
      port       <= 1'b0;
      cnt        <= '0;
      done_q     <= '0;
      err_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
      address_q  <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      read_q     <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            last <= gnt;
            port <= gnt;
            if (range_bad) begin
              done_q[gnt] <= 1'b1;
              err_q[gnt]  <= 1'b1;
            end else if (sel_write) begin
              write_q   <= 1'b1;
              address_q <= acc_addr;
              wdata_q   <= sel_wdata;
              state     <= WRITE;
            end else begin
              read_q    <= 1'b1;
              address_q <= acc_addr;
              cnt       <= '0;
              state     <= READ;
            end
          end
        end
        WRITE: begin
          write_q      <= 1'b0;
          done_q[port] <= 1'b1;
          state        <= IDLE;
        end
        READ: begin
          if (bus.mem_ready) begin
            read_q        <= 1'b0;
            done_q[port]  <= 1'b1;
            rdata_q[port] <= bus.mem_block_data;
            state         <= DRAIN;
          end else if (cnt == 4'(TIMEOUT - 1)) begin
            read_q       <= 1'b0;
            done_q[port] <= 1'b1;
            err_q[port]  <= 1'b1;
            state        <= DRAIN;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DRAIN: begin
          // stale ready pulses from this read must not complete the next one
          if (!bus.mem_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_done      = done_q[0];
  assign bus.req1_done      = done_q[1];
  assign bus.req0_err       = err_q[0];
  assign bus.req1_err       = err_q[1];
  assign bus.req0_rdata     = rdata_q[0];
  assign bus.req1_rdata     = rdata_q[1];
  assign bus.mem_address    = address_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_write      = write_q;
  assign bus.mem_read       = read_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
// Expected grant order, completion times and data come from a transaction-level model.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0;
  int   fails = 0;
  int   edges = 0;
  logic stall = 1'b0;
  logic rd_p1 = 1'b0;
  logic init_done = 1'b0;

  logic [7:0]   mem     [1024];
  logic [7:0]   ref_mem [1024];
  logic [127:0] exp_rdata [2];
  logic         last_gnt = 1'b1;
  logic [31:0]  seen_wr_addr;
  logic [31:0]  seen_rd_addr;
  int           seen_rd_cyc;
  int           seen_wr_cyc;

  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter #(.MEM_BYTES(1024), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 13) ^ ((i >> 4) * 91) ^ 8'h5A);
  endfunction

  // memory: ready follows mem_read by two edges; stall suppresses ready entirely
  always @(posedge clk) begin
    edges <= edges + 1;
    rd_p1 <= bus.mem_read;
    bus.mem_ready <= rd_p1 & ~stall;
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
      init_done <= 1'b1;
    end else begin
      if (rd_p1)
        for (int i = 0; i < 16; i++)
          bus.mem_block_data[8*i +: 8] <= mem[{bus.mem_address[9:4], 4'(i)}];
      if (bus.mem_write)
        for (int i = 0; i < 8; i++)
          mem[{bus.mem_address[9:3], 3'(i)}] <= bus.mem_write_data[8*i +: 8];
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic w, input logic [31:0] a,
                         input logic [63:0] d);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  function automatic logic get_done(input int p);
    return (p == 0) ? bus.req0_done : bus.req1_done;
  endfunction

  function automatic logic get_err(input int p);
    return (p == 0) ? bus.req0_err : bus.req1_err;
  endfunction

  function automatic logic [127:0] get_rdata(input int p);
    return (p == 0) ? bus.req0_rdata : bus.req1_rdata;
  endfunction

  function automatic logic is_bad(input logic w, input logic [31:0] a);
    longint sz   = w ? 64'd8 : 64'd16;
    longint base = longint'(a) - (longint'(a) % sz);
    return (base + sz) > 1024;
  endfunction

  function automatic logic [127:0] ref_block(input logic [31:0] a);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_mem[{a[9:4], 4'(i)}];
    return r;
  endfunction

  // Issue up to one request per port from IDLE and check the whole exchange.
  // Grant-relative costs: range error done +0 / next grant +1, write +1/+2,
  // read +3/+7, timed-out read +15/+17.
  task automatic do_ops(input logic [1:0] v, input logic [1:0] w,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [63:0] d0, input logic [63:0] d1);
    logic [31:0] a [2];
    logic [63:0] d [2];
    int   exp_t [2];
    int   got_t [2];
    logic exp_e [2];
    int   ord [2];
    int   n, g, base, rel, exp_rd, exp_wr;
    logic first;
    logic all_done;
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    first  = (v[0] & v[1]) ? ~last_gnt : v[1];
    ord[0] = int'(first);
    ord[1] = int'(~first);
    n      = int'(v[0]) + int'(v[1]);
    g = 1; exp_rd = 0; exp_wr = 0;
    exp_t[0] = -1; exp_t[1] = -1; exp_e[0] = 1'b0; exp_e[1] = 1'b0;
    for (int k = 0; k < n; k++) begin
      int p, lat, span;
      p = ord[k];
      if (is_bad(w[p], a[p])) begin
        exp_e[p] = 1'b1; lat = 0; span = 1;
      end else if (w[p]) begin
        lat = 1; span = 2; exp_wr++;
        for (int i = 0; i < 8; i++) ref_mem[{a[p][9:3], 3'(i)}] = d[p][8*i +: 8];
      end else if (stall) begin
        exp_e[p] = 1'b1; lat = 15; span = 17; exp_rd += 15;
      end else begin
        lat = 3; span = 7; exp_rd += 3;
        exp_rdata[p] = ref_block(a[p]);
      end
      exp_t[p] = g + lat;
      g += span;
      last_gnt = p[0];
    end

    set_req(0, v[0], w[0], a0, d0);
    set_req(1, v[1], w[1], a1, d1);
    base = edges; got_t[0] = -1; got_t[1] = -1;
    seen_rd_cyc = 0; seen_wr_cyc = 0; all_done = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      rel = edges - base;
      if (bus.mem_read)  begin seen_rd_cyc++; seen_rd_addr = bus.mem_address; end
      if (bus.mem_write) begin seen_wr_cyc++; seen_wr_addr = bus.mem_address; end
      if (bus.req0_done | bus.req1_done)
        check("done_exclusive", {127'd0, bus.req0_done & bus.req1_done}, 128'd0);
      for (int p = 0; p < 2; p++) begin
        if (get_done(p)) begin
          got_t[p] = rel;
          check($sformatf("p%0d_err", p), {127'd0, get_err(p)}, {127'd0, exp_e[p]});
          check($sformatf("p%0d_rdata", p), get_rdata(p), exp_rdata[p]);
          set_req(p, 1'b0, 1'b0, 32'd0, 64'd0);
        end
      end
      all_done = (!v[0] || got_t[0] >= 0) && (!v[1] || got_t[1] >= 0);
      if (all_done && rel >= g - 1) break;
    end
    check("op_complete", {127'd0, all_done}, 128'd1);
    check("p0_done_time", 128'(got_t[0]), 128'(exp_t[0]));
    check("p1_done_time", 128'(got_t[1]), 128'(exp_t[1]));
    check("read_strobe_cycles", 128'(seen_rd_cyc), 128'(exp_rd));
    check("write_strobe_cycles", 128'(seen_wr_cyc), 128'(exp_wr));
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'h3F0 + $urandom_range(0, 31);
      1:       return $urandom;
      default: return $urandom_range(0, 1023);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    set_req(0, 1'b0, 1'b0, 32'd0, 64'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 64'd0);

    repeat (3) @(negedge clk);
    check("rst_mem_read", {127'd0, bus.mem_read}, 128'd0);
    check("rst_mem_write", {127'd0, bus.mem_write}, 128'd0);
    check("rst_done0", {127'd0, bus.req0_done}, 128'd0);
    check("rst_done1", {127'd0, bus.req1_done}, 128'd0);
    check("rst_err0", {127'd0, bus.req0_err}, 128'd0);
    check("rst_address", {96'd0, bus.mem_address}, 128'd0);
    check("rst_rdata0", bus.req0_rdata, 128'd0);
    check("rst_rdata1", bus.req1_rdata, 128'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // first tie after reset goes to port 0, port 1 follows 7 edges later
    do_ops(2'b11, 2'b00, 32'h100, 32'h210, 64'd0, 64'd0);

    do_ops(2'b10, 2'b10, 32'd0, 32'h40, 64'd0, 64'h1122334455667788);
    check("wr_address", {96'd0, seen_wr_addr}, 128'h40);
    do_ops(2'b01, 2'b00, 32'h48, 32'd0, 64'd0, 64'd0);
    check("rd_address", {96'd0, seen_rd_addr}, 128'h40);
    check("rd_dword0", {64'd0, bus.req0_rdata[63:0]}, 128'h1122334455667788);

    repeat (3) do_ops(2'b11, 2'b00, rand_addr() & 32'h3FF, rand_addr() & 32'h3FF, 64'd0, 64'd0);

    do_ops(2'b01, 2'b00, 32'h100, 32'd0, 64'd0, 64'd0);
    do_ops(2'b01, 2'b00, 32'h200, 32'd0, 64'd0, 64'd0);

    do_ops(2'b01, 2'b00, 32'h3F8, 32'd0, 64'd0, 64'd0);
    do_ops(2'b01, 2'b00, 32'h400, 32'd0, 64'd0, 64'd0);
    do_ops(2'b10, 2'b10, 32'd0, 32'h3FC, 64'd0, 64'hA5A5_0123_4567_89AB);
    check("edge_wr_address", {96'd0, seen_wr_addr}, 128'h3F8);
    do_ops(2'b10, 2'b00, 32'd0, 32'h3F8, 64'd0, 64'd0);
    do_ops(2'b10, 2'b00, 32'd0, 32'hFFFF_FFF8, 64'd0, 64'd0);
    do_ops(2'b11, 2'b01, 32'h400, 32'h3F0, 64'h77, 64'd0);

    stall = 1'b1;
    do_ops(2'b10, 2'b00, 32'd0, 32'h80, 64'd0, 64'd0);
    stall = 1'b0;

    // reset while a read is outstanding
    set_req(0, 1'b1, 1'b0, 32'h80, 64'd0);
    repeat (2) @(negedge clk);
    check("mid_read_active", {127'd0, bus.mem_read}, 128'd1);
    rst_n = 1'b0;
    #1;
    check("async_mem_read", {127'd0, bus.mem_read}, 128'd0);
    check("async_done0", {127'd0, bus.req0_done}, 128'd0);
    check("async_rdata1", bus.req1_rdata, 128'd0);
    set_req(0, 1'b0, 1'b0, 32'd0, 64'd0);
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    last_gnt = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_ops(2'b11, 2'b00, 32'h20, 32'h30, 64'd0, 64'd0);

    for (int it = 0; it < 40; it++) begin
      logic [1:0] v;
      v = 2'($urandom_range(1, 3));
      stall = ($urandom_range(0, 9) == 0);
      do_ops(v, 2'($urandom), rand_addr(), rand_addr(),
             {$urandom, $urandom}, {$urandom, $urandom});
      stall = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter and sequencer in front of the byte-addressed 1 KB data memory (64-bit write, 128-bit block read, two-cycle-delayed `mem_ready`). It lets the instruction-cache refill port (port 0) and the data-cache refill/write-through port (port 1) share the memory. It drives the memory's address, read and write strobes, waits out the memory's ready latency and drain, and returns completions on the winning port.

## Interface
- `MEM_BYTES`, 1024: memory size in bytes; used for the range check.
- `TIMEOUT`, 15: maximum cycles spent in READ before aborting.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  request pending; held high with fields stable until the matching `done`.
- `req0_write`, `req1_write`  in  1  1 = 64-bit write, 0 = 128-bit block read.
- `req0_addr`, `req1_addr`  in  32  byte address.
- `req0_wdata`, `req1_wdata`  in  64  write data.
- `req0_done`, `req1_done`  out  1  one-cycle completion pulse.
- `req0_err`, `req1_err`  out  1  valid with `done`; 1 = range error or timeout.
- `req0_rdata`, `req1_rdata`  out  128  read block; updated only on a successful read `done`, otherwise held.
- `mem_address`  out  32  to memory `address`.
- `mem_write_data`  out  64  to memory `write_data`.
- `mem_write`  out  1  to memory `mem_write`.
- `mem_read`  out  1  to memory `mem_read`.
- `mem_block_data`  in  128  from memory `block_read_data`.
- `mem_ready`  in  1  from memory `mem_ready`.

## Operation
- All outputs are registered. Reset (asynchronous) value of every output is 0; the state is IDLE and the round-robin pointer is set so port 0 wins the first tie.
- FSM states are IDLE, READ, WRITE and DRAIN.
- **IDLE**
  - Arbitrate among ports with `valid` high. With one requester, it wins. With both, the port not granted last wins.
  - Update the pointer on every grant.
- **Range check at grant**
  - Reads are aligned: `mem_address = {addr[31:4], 4'b0}`. Writes are aligned: `{addr[31:3], 3'b0}`.
  - If the aligned address + access size (16 or 8) > `MEM_BYTES`, issue no memory access.
  - Pulse `done` with `err = 1` on the next edge and stay in IDLE.
- **WRITE**
  - Entered with `mem_write = 1` and address/data registered.
  - After exactly one cycle, deassert `mem_write`, pulse `done` (`err = 0`) and return to IDLE.
  - Writes never enter DRAIN.
- **READ**
  - Entered with `mem_read = 1`; hold address and `mem_read` stable.
  - On the first edge that samples `mem_ready = 1`:
    - capture `mem_block_data` into that port's `rdata`;
    - pulse `done` (`err = 0`);
    - deassert `mem_read`;
    - go to DRAIN.
  - A 4-bit cycle counter counts READ cycles. When it reaches `TIMEOUT` without `mem_ready`:
    - deassert `mem_read`;
    - pulse `done` with `err = 1` (`rdata` unchanged);
    - go to DRAIN.
- **DRAIN**
  - `mem_read = 0`. Stay until `mem_ready` is sampled 0, then go to IDLE.
  - Purpose: the stale `mem_ready` pipeline must empty so that a following read cannot complete early with wrong data.
- Only one access is in flight at a time. `done` is never asserted on both ports in the same cycle.
- Deasserting `valid` before `done` is a protocol violation; behaviour is unspecified, and the bench must not do it.

## Timing
- Edge numbering: E0 is the edge at which IDLE grants the request.
- **Write:** `mem_write` is high in the cycle after E0. The memory writes at E1, and `done` is high in the cycle after E1. The next grant is possible at E2.
- **Read:** `mem_read` is high after E0. `mem_ready` rises after E2 and is sampled at E3. `rdata` and `done` are valid after E3, so read latency is 3 edges from grant.
  - In DRAIN, `mem_ready` is still 1 at the E4 and E5 samples and 0 at E6, so the return to IDLE happens at E6.
  - The next grant is possible at E7. Back-to-back read throughput is 1 per 7 cycles.
- **Range error:** `done`/`err` is high after E0; no memory strobe is asserted.
- **Simultaneous `valid` in IDLE:** exactly one grant per the pointer; the loser waits, with its request held, until the next IDLE.
- **New `valid` during READ/WRITE/DRAIN:** ignored until IDLE.
- **Reset mid-operation:** `mem_read`/`mem_write`/`done` drop immediately (async) and no `done` is produced for the aborted request. After reset the bench must wait 2 cycles before the first request, or DRAIN logic handles residual `mem_ready` by starting in IDLE only after `mem_ready` is sampled 0.
- **Address bit 3 on reads** is ignored (16-byte block); the requester selects its dword.

## Test plan
- Port 1 writes 0x1122334455667788 to 0x40 → `mem_write` high for 1 cycle with `mem_address = 0x40`, `req1_done` after E1. Then port 0 reads 0x48 → `mem_address = 0x40`, `req0_rdata[63:0] = 0x1122334455667788`, `done` after E3, `err = 0`.
- Both ports `valid` (reads) from reset → port 0 granted first, port 1 granted at E7 after the first grant. Repeated contention alternates 0,1,0,1 with no starvation.
- Read, then an immediate second read from the same port to a different block → the second `mem_read` rises no earlier than 7 cycles after the first grant, and the second `rdata` matches the second block, not the first.
- Read of 0x3F8 (block 0x3F0 fits) → `err = 0`. Read of 0x400 and write of 0x3FC aligned to 0x3F8 (fits) → read `err = 1` with no `mem_read` pulse; the write succeeds.
- Memory model holds `mem_ready = 0` → after 15 READ cycles `done = 1`, `err = 1`, `rdata` unchanged, FSM back in IDLE.
- Assert `rst_n = 0` while in READ → `mem_read` and `done` are 0 immediately. Both ports are serviceable after release, and port 0 wins the first tie.
